// File: rtl/calc_pkg.sv
// Shared definitions for the signed calculator sequencing stage: datapath
// width, opcode encodings and the controller state type.
package calc_pkg;

  localparam int WIDTH = 3;

  typedef logic [1:0] calc_op_t;

  localparam calc_op_t OP_ADD  = 2'b00;
  localparam calc_op_t OP_SUB  = 2'b01;
  localparam calc_op_t OP_NEG  = 2'b10;
  localparam calc_op_t OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } calc_state_t;

endpackage : calc_pkg

// File: rtl/calc_opnd_mux.sv
// Operand former: turns the registered operands and opcode into the
// effective adder operands and carry-in. Subtraction and negation use the
// invert-and-add-one identity so the external adder only ever adds.
module calc_opnd_mux
  import calc_pkg::*;
#(
  parameter int WIDTH = calc_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  calc_op_t         i_op,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  output logic             o_add_cin
);

  // Select effective operands and carry-in per opcode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a value unassigned, which would infer a latch.
    o_add_a   = '0;
    o_add_b   = '0;
    o_add_cin = 1'b0;
    unique case (i_op)
      OP_ADD: begin
        o_add_a = i_a;
        o_add_b = i_b;
      end
      OP_SUB: begin
        o_add_a   = i_a;
        o_add_b   = ~i_b;
        o_add_cin = 1'b1;
      end
      OP_NEG: begin
        o_add_b   = ~i_a;
        o_add_cin = 1'b1;
      end
      default: ;  // reserved opcode: adder sees all zeros
    endcase
  end

endmodule : calc_opnd_mux

// File: rtl/calc_ctrl.sv
// Sequencing stage around the external ripple adder. Accepts an operation
// over valid/ready, presents effective operands to the adder for one cycle,
// captures sum/carry plus the signed overflow flag, and holds the result on
// a valid/ready output until consumed.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = calc_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  // operation input
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  // external adder
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  // result output
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             out_cout,
  output logic             out_err
);

  calc_state_t      r_state;
  calc_state_t      w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  calc_op_t         r_op;

  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_cout;
  logic             r_err;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_cin;
  logic             w_ovf;
  logic             w_rsvd;

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & out_ready;

  // Effective operands come only from registered values, so nothing on the
  // in_* ports reaches the adder combinationally.
  calc_opnd_mux #(
    .WIDTH(WIDTH)
  ) u_opnd_mux (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_add_a  (w_add_a),
    .o_add_b  (w_add_b),
    .o_add_cin(w_add_cin)
  );

  // Signed overflow: operands of equal sign producing a sum of the other sign.
  assign w_ovf  = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &
                  (add_sum[WIDTH-1] != w_add_a[WIDTH-1]);
  assign w_rsvd = (r_op == OP_RSVD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; DONE goes straight to EXEC when a new operation is
  // accepted in the same cycle the result drains, giving a 2-cycle cadence.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_in_fire) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_DONE;
      ST_DONE: begin
        if (w_in_fire)       w_next_state = ST_EXEC;
        else if (w_out_fire) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready stays low while in reset.
  always_comb begin
    w_in_ready  = rst_n & ((r_state == ST_IDLE) |
                           ((r_state == ST_DONE) & out_ready));
    w_out_valid = (r_state == ST_DONE);
  end

  // Operand registers load only on an accepted input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= OP_ADD;
    end else if (w_in_fire) begin
      r_a  <= in_a;
      r_b  <= in_b;
      r_op <= in_op;
    end
  end

  // Result registers capture the adder in EXEC and hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_cout   <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_result <= w_rsvd ? '0   : add_sum;
      r_ovf    <= w_rsvd ? 1'b0 : w_ovf;
      r_cout   <= w_rsvd ? 1'b0 : add_cout;
      r_err    <= w_rsvd;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign add_a      = w_add_a;
  assign add_b      = w_add_b;
  assign add_cin    = w_add_cin;
  assign out_result = r_result;
  assign out_ovf    = r_ovf;
  assign out_cout   = r_cout;
  assign out_err    = r_err;

endmodule : calc_ctrl

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: a behavioural adder closes the loop, a
// driver pushes expected results computed with signed integer arithmetic,
// and an independent monitor checks latency, adder operands, backpressure
// stability and every consumed result.
module tb_calc_ctrl;

  localparam int W = 3;

  typedef struct packed {
    logic [W-1:0] result;
    logic         ovf;
    logic         cout;
    logic         err;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } opnd_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [1:0]   in_op;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_ovf, out_cout, out_err;

  int errors = 0;
  int checks = 0;

  exp_t  exp_q[$];
  opnd_t opnd_q[$];

  logic rand_rdy  = 1'b0;
  logic rdy_force = 1'b1;

  always #5 clk = ~clk;

  // External ripple adder stand-in.
  logic [W:0] sum_full;
  assign sum_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum  = sum_full[W-1:0];
  assign add_cout = sum_full[W];

  calc_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_ovf   (out_ovf),
    .out_cout  (out_cout),
    .out_err   (out_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: true signed arithmetic; overflow means out of [-4,3].
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    exp_t e;
    int sa, sb, ua, ub, r;
    logic c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    r  = 0;
    c  = 1'b0;
    case (op)
      2'b00: begin r = sa + sb; c = (ua + ub) >= 8; end
      2'b01: begin r = sa - sb; c = (ua >= ub);     end
      2'b10: begin r = -sa;     c = (ua == 0);      end
      default: ;
    endcase
    e.result = r[W-1:0];
    e.ovf    = (op != 2'b11) && (r < -4 || r > 3);
    e.cout   = c;
    e.err    = (op == 2'b11);
    return e;
  endfunction

  function automatic opnd_t opnd_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    opnd_t o;
    case (op)
      2'b00:   o = '{a: a,  b: b,  cin: 1'b0};
      2'b01:   o = '{a: a,  b: ~b, cin: 1'b1};
      2'b10:   o = '{a: '0, b: ~a, cin: 1'b1};
      default: o = '0;
    endcase
    return o;
  endfunction

  // Output ready: forced value or random, applied at posedge+2.
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Monitor: independent of the driver, decides everything from pins.
  logic         acc_d1 = 1'b0, acc_d2 = 1'b0, stall_prev = 1'b0;
  logic [W-1:0] held_result;
  logic         held_ovf, held_cout, held_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_d1     = 1'b0;
      acc_d2     = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (acc_d2) check("latency_out_valid", 32'(out_valid), 32'd1);
      if (acc_d1) begin
        if (opnd_q.size() == 0) begin
          check("opnd_queue_nonempty", 32'd0, 32'd1);
        end else begin
          opnd_t o;
          o = opnd_q.pop_front();
          check("add_a", 32'(add_a), 32'(o.a));
          check("add_b", 32'(add_b), 32'(o.b));
          check("add_cin", 32'(add_cin), 32'(o.cin));
        end
      end
      if (stall_prev) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_result_held", 32'({out_result, out_ovf, out_cout, out_err}),
              32'({held_result, held_ovf, held_cout, held_err}));
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready_low", 32'(in_ready), 32'd0);
        held_result = out_result;
        held_ovf    = out_ovf;
        held_cout   = out_cout;
        held_err    = out_err;
        stall_prev  = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        check("done_in_ready_high", 32'(in_ready), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_result", 32'(out_result), 32'(e.result));
          check("out_ovf", 32'(out_ovf), 32'(e.ovf));
          check("out_cout", 32'(out_cout), 32'(e.cout));
          check("out_err", 32'(out_err), 32'(e.err));
        end
      end
      acc_d2 = acc_d1;
      acc_d1 = in_valid && in_ready;
    end
  end

  // Drive one operation; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, op));
        opnd_q.push_back(opnd_model(a, b, op));
        break;
      end
      if (n >= 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_outputs"}, 32'({out_result, out_ovf, out_cout, out_err}), 32'd0);
    check({tag, "_add"}, 32'({add_a, add_b, add_cin}), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_op    = '0;
    #1;
    check_reset_values("reset");
    check("reset_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    check_reset_values("post_reset");
    @(posedge clk);
    #1;

    // Directed operations from the test plan.
    send(3'b011, 3'b010, 2'b00);
    send(3'b010, 3'b011, 2'b01);
    send(3'b100, 3'b000, 2'b10);
    send(3'b001, 3'b000, 2'b10);
    send(3'b101, 3'b110, 2'b11);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: stall 5 cycles with a second operation waiting.
    rdy_force = 1'b0;
    send(3'b001, 3'b010, 2'b00);
    fork
      send(3'b110, 3'b011, 2'b01);
      begin
        repeat (6) @(posedge clk);
        #1;
        rdy_force = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic with random downstream stalls and gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(W'($urandom), W'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    // Continuous ADDs, then reset while an operation is in EXEC.
    send(3'b001, 3'b001, 2'b00);
    send(3'b010, 3'b001, 2'b00);
    send(3'b111, 3'b111, 2'b00);
    send(3'b100, 3'b111, 2'b00);
    send(3'b011, 3'b011, 2'b00);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    check("mid_reset_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    opnd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_reset_no_valid", 32'(out_valid), 32'd0);
      check("after_reset_in_ready", 32'(in_ready), 32'd1);
    end
    check_reset_values("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_calc_ctrl

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing stage that sits directly upstream and downstream of the 3-bit ripple adder in the signed calculator datapath. It accepts an operand pair and opcode over a valid/ready handshake and forms the adder's effective operands and carry-in for ADD, SUB and NEG. It then captures the adder's sum and carry, computes the signed overflow flag, and holds the result on a valid/ready output until it is consumed. The adder itself stays external and is wired between `add_*` outputs and `add_sum`/`add_cout` inputs at calculator top level.

## Interface
- `WIDTH`, default 3: operand/result width in bits, two's complement. Only 3 is legal with the existing adder.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the operand/opcode fields below are valid.
- `in_ready` out 1: the block can accept a new operation.
- `in_a` in WIDTH: operand A, signed.
- `in_b` in WIDTH: operand B, signed; ignored for NEG.
- `in_op` in 2: operation select. 00 ADD, 01 SUB, 10 NEG (result = −A), 11 reserved.
- `add_a` out WIDTH: effective operand A to the adder.
- `add_b` out WIDTH: effective operand B to the adder.
- `add_cin` out 1: carry-in to the adder.
- `add_sum` in WIDTH: sum from the adder, combinational on `add_a`/`add_b`/`add_cin`.
- `add_cout` in 1: carry-out from the adder.
- `out_valid` out 1: the result fields below are valid.
- `out_ready` in 1: downstream consumes the result.
- `out_result` out WIDTH: signed result.
- `out_ovf` out 1: signed overflow.
- `out_cout` out 1: raw adder carry-out.
- `out_err` out 1: the opcode was reserved.

## Operation
- **FSM states:** IDLE, EXEC, DONE.
  - IDLE → EXEC on input handshake.
  - EXEC → DONE unconditionally.
  - DONE → IDLE on output handshake, or DONE → EXEC if an input handshake occurs in the same cycle.
- **Input handshake:** `in_ready = rst_n & (state==IDLE | (state==DONE & out_ready))`. A transfer occurs when `in_valid & in_ready`; `in_a`, `in_b` and `in_op` are then registered.
- **Effective operands (from registered values):**
  - ADD: `add_a`=A, `add_b`=B, `add_cin`=0.
  - SUB: `add_a`=A, `add_b`=~B, `add_cin`=1.
  - NEG: `add_a`=0, `add_b`=~A, `add_cin`=1.
  - Reserved: all zero.
- **Capture in EXEC:**
  - `out_result` ← `add_sum`
  - `out_cout` ← `add_cout`
  - `out_ovf` ← (`add_a[W-1]` == `add_b[W-1]`) & (`add_sum[W-1]` != `add_a[W-1]`)
  - `out_err` ← (op==11)
  - For a reserved opcode, `out_result`, `out_ovf` and `out_cout` are forced to 0.
- **Wrap-around:** the result is always the low WIDTH bits. The overflow flag is the only range indication, and the result is never saturated.
- **Output handshake:** a transfer occurs when `out_valid & out_ready`. The result registers hold stable while `out_valid=1` and `out_ready=0`.

## Timing
- **Reset values (while `rst_n` low and immediately after):** state=IDLE, `in_ready`=0 (1 once `rst_n` is high), `out_valid`=0, `out_result`=000, `out_ovf`=0, `out_cout`=0, `out_err`=0, `add_a`=`add_b`=000, `add_cin`=0.
- **Latency:** input accepted at edge k; `add_*` driven during cycle k→k+1; `out_valid`=1 and result valid from edge k+1.
- **Throughput:** with `out_ready` held high and `in_valid` continuous, one operation every 2 cycles, because DONE→EXEC bypasses IDLE.
- **Backpressure:** while `out_valid` is stalled, `in_ready`=0 and all outputs are frozen.
- **Reset mid-operation:** reset asserted in EXEC or DONE discards the operation. No `out_valid` pulse occurs after release.
- **Register boundaries:** all outputs except `in_ready` are registered. There is no combinational path from `in_*` to any output, nor from `add_sum` to any output.

## Structure
- **Shared package `calc_pkg`:** `WIDTH` constant (3), opcode constants `OP_ADD`/`OP_SUB`/`OP_NEG`/`OP_RSVD`, FSM state enum `calc_state_t`.
- **One sub-module, `calc_opnd_mux`:** combinational; maps registered A, B and op to `add_a`/`add_b`/`add_cin`.
- **Top module `calc_ctrl`:** holds the FSM, the operand and result registers, and the overflow logic.

## Test plan
- ADD A=011, B=010 → `out_result`=101, `out_ovf`=1, `out_cout`=0, `out_valid` one cycle after acceptance.
- SUB A=010, B=011 → `add_b`=100, `add_cin`=1; `out_result`=111 (−1), `out_ovf`=0, `out_cout`=0.
- NEG A=100 (−4) → `out_result`=100, `out_ovf`=1. NEG A=001 → `out_result`=111, `out_ovf`=0.
- op=11, A=101, B=110 → `out_result`=000, `out_err`=1, `out_ovf`=0.
- `out_ready` low for 5 cycles after `out_valid`, `in_valid` high → result stable, `in_ready`=0. `out_ready` high → second operation accepted in the same cycle, its `out_valid` 1 cycle later.
- Continuous traffic, `out_ready`=1, 4 ADDs (001+001, 010+001, 111+111, 100+111) → 010, 011, 110 (ovf 0, cout 1), 011 (ovf 1, cout 1) at a 2-cycle cadence. Then `rst_n` low during EXEC → no `out_valid`, all outputs at reset values.
